// File: rtl/decoder.sv
// decoder: registered RV32I field, format and immediate decode with 1-cycle latency
module decoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instruction,
  input  logic        in_valid,
  output logic [6:0]  opcode,
  output logic [4:0]  rd,
  output logic [2:0]  funct3,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [6:0]  funct7,
  output logic [31:0] imm,
  output logic [2:0]  fmt,
  output logic        illegal,
  output logic        out_valid
);
  localparam logic [2:0] FMT_R = 3'd0, FMT_I = 3'd1, FMT_S = 3'd2, FMT_B = 3'd3,
                         FMT_U = 3'd4, FMT_J = 3'd5, FMT_X = 3'd7;
  logic [6:0]  op;
  logic [2:0]  fmt_n;
  logic [31:0] imm_n;
  logic        s;
  assign op = instruction[6:0];
  assign s  = instruction[31];
  always_comb begin
    fmt_n = (op == 7'b0110011) ? FMT_R :
            (op == 7'b0010011 || op == 7'b0000011 || op == 7'b1100111 ||
             op == 7'b1110011 || op == 7'b0001111) ? FMT_I :
            (op == 7'b0100011) ? FMT_S :
            (op == 7'b1100011) ? FMT_B :
            (op == 7'b0110111 || op == 7'b0010111) ? FMT_U :
            (op == 7'b1101111) ? FMT_J : FMT_X;
    imm_n = (fmt_n == FMT_I) ? {{20{s}}, instruction[31:20]} :
            (fmt_n == FMT_S) ? {{20{s}}, instruction[31:25], instruction[11:7]} :
            (fmt_n == FMT_B) ? {{19{s}}, s, instruction[7], instruction[30:25], instruction[11:8], 1'b0} :
            (fmt_n == FMT_U) ? {instruction[31:12], 12'b0} :
            (fmt_n == FMT_J) ? {{11{s}}, s, instruction[19:12], instruction[20], instruction[30:21], 1'b0} :
            32'b0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcode    <= '0;
      rd        <= '0;
      funct3    <= '0;
      rs1       <= '0;
      rs2       <= '0;
      funct7    <= '0;
      imm       <= '0;
      fmt       <= '0;
      illegal   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        opcode  <= op;
        rd      <= instruction[11:7];
        funct3  <= instruction[14:12];
        rs1     <= instruction[19:15];
        rs2     <= instruction[24:20];
        funct7  <= instruction[31:25];
        imm     <= imm_n;
        fmt     <= fmt_n;
        illegal <= (fmt_n == FMT_X);
      end
    end
  end
endmodule

// File: tb/tb_decoder.sv
// tb_decoder: table-driven checks of decoder fields, plus hold and async-reset sequences
module tb_decoder;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instruction;
  logic        in_valid;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic [2:0]  fmt;
  logic        illegal;
  logic        out_valid;
  int          total = 0;
  int          passed = 0;

  decoder dut (
    .clk(clk), .rst_n(rst_n), .instruction(instruction), .in_valid(in_valid),
    .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2),
    .funct7(funct7), .imm(imm), .fmt(fmt), .illegal(illegal), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } vec_t;

  vec_t vecs[20];
  vec_t zero_v;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic chk_all(input string tag, input vec_t v, input logic ov);
    chk({tag, " opcode"}, 32'(opcode), 32'(v.op));
    chk({tag, " rd"}, 32'(rd), 32'(v.rd));
    chk({tag, " funct3"}, 32'(funct3), 32'(v.f3));
    chk({tag, " rs1"}, 32'(rs1), 32'(v.rs1));
    chk({tag, " rs2"}, 32'(rs2), 32'(v.rs2));
    chk({tag, " funct7"}, 32'(funct7), 32'(v.f7));
    chk({tag, " imm"}, imm, v.imm);
    chk({tag, " fmt"}, 32'(fmt), 32'(v.fmt));
    chk({tag, " illegal"}, 32'(illegal), 32'(v.ill));
    chk({tag, " out_valid"}, 32'(out_valid), 32'(ov));
  endtask

  task automatic apply(input logic [31:0] w, input logic v);
    @(negedge clk);
    instruction = w;
    in_valid = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            instr         op     rd     f3    rs1    rs2    f7     imm           fmt   ill
    vecs[0]  = '{32'h00000033, 7'h33, 5'd0,  3'd0, 5'd0,  5'd0,  7'h00, 32'h00000000, 3'd0, 1'b0};
    vecs[1]  = '{32'h00108093, 7'h13, 5'd1,  3'd0, 5'd1,  5'd1,  7'h00, 32'h00000001, 3'd1, 1'b0};
    vecs[2]  = '{32'h00112023, 7'h23, 5'd0,  3'd2, 5'd2,  5'd1,  7'h00, 32'h00000000, 3'd2, 1'b0};
    vecs[3]  = '{32'h00000063, 7'h63, 5'd0,  3'd0, 5'd0,  5'd0,  7'h00, 32'h00000000, 3'd3, 1'b0};
    vecs[4]  = '{32'hFFF00093, 7'h13, 5'd1,  3'd0, 5'd0,  5'd31, 7'h7F, 32'hFFFFFFFF, 3'd1, 1'b0};
    vecs[5]  = '{32'h00000013, 7'h13, 5'd0,  3'd0, 5'd0,  5'd0,  7'h00, 32'h00000000, 3'd1, 1'b0};
    vecs[6]  = '{32'h00000000, 7'h00, 5'd0,  3'd0, 5'd0,  5'd0,  7'h00, 32'h00000000, 3'd7, 1'b1};
    vecs[7]  = '{32'h80000537, 7'h37, 5'd10, 3'd0, 5'd0,  5'd0,  7'h40, 32'h80000000, 3'd4, 1'b0};
    vecs[8]  = '{32'h0080006F, 7'h6F, 5'd0,  3'd0, 5'd0,  5'd8,  7'h00, 32'h00000008, 3'd5, 1'b0};
    vecs[9]  = '{32'h001FF06F, 7'h6F, 5'd0,  3'd7, 5'd31, 5'd1,  7'h00, 32'h000FF800, 3'd5, 1'b0};
    vecs[10] = '{32'hFFFFF0EF, 7'h6F, 5'd1,  3'd7, 5'd31, 5'd31, 7'h7F, 32'hFFFFFFFE, 3'd5, 1'b0};
    vecs[11] = '{32'h000000E3, 7'h63, 5'd1,  3'd0, 5'd0,  5'd0,  7'h00, 32'h00000800, 3'd3, 1'b0};
    vecs[12] = '{32'h80000063, 7'h63, 5'd0,  3'd0, 5'd0,  5'd0,  7'h40, 32'hFFFFF000, 3'd3, 1'b0};
    vecs[13] = '{32'h800000A3, 7'h23, 5'd1,  3'd0, 5'd0,  5'd0,  7'h40, 32'hFFFFF801, 3'd2, 1'b0};
    vecs[14] = '{32'h12345297, 7'h17, 5'd5,  3'd5, 5'd8,  5'd3,  7'h09, 32'h12345000, 3'd4, 1'b0};
    vecs[15] = '{32'h80002003, 7'h03, 5'd0,  3'd2, 5'd0,  5'd0,  7'h40, 32'hFFFFF800, 3'd1, 1'b0};
    vecs[16] = '{32'h00000073, 7'h73, 5'd0,  3'd0, 5'd0,  5'd0,  7'h00, 32'h00000000, 3'd1, 1'b0};
    vecs[17] = '{32'h0000000F, 7'h0F, 5'd0,  3'd0, 5'd0,  5'd0,  7'h00, 32'h00000000, 3'd1, 1'b0};
    vecs[18] = '{32'h40000033, 7'h33, 5'd0,  3'd0, 5'd0,  5'd0,  7'h20, 32'h00000000, 3'd0, 1'b0};
    vecs[19] = '{32'hFFFFFFFF, 7'h7F, 5'd31, 3'd7, 5'd31, 5'd31, 7'h7F, 32'h00000000, 3'd7, 1'b1};
    zero_v   = '{32'h0, 7'h0, 5'd0, 3'd0, 5'd0, 5'd0, 7'h0, 32'h0, 3'd0, 1'b0};

    rst_n = 1'b0;
    instruction = 32'hFFFFFFFF;
    in_valid = 1'b1;
    #1;
    chk_all("reset", zero_v, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) apply(vecs[i].instr, 1'b1);
    for (int i = 0; i < 20; i++) begin
      apply(vecs[i].instr, 1'b1);
      chk_all($sformatf("vec%0d", i), vecs[i], 1'b1);
    end

    // Outputs must hold the last loaded word while in_valid is low
    apply(32'h00108093, 1'b0);
    chk_all("hold1", vecs[19], 1'b0);
    apply(32'h00000033, 1'b0);
    chk_all("hold2", vecs[19], 1'b0);
    apply(32'h00000063, 1'b1);
    chk_all("after_hold", vecs[3], 1'b1);

    // Async reset mid-cycle with a word in flight clears everything at once
    @(negedge clk);
    instruction = 32'hFFF00093;
    in_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", zero_v, 1'b0);
    @(posedge clk);
    #1;
    chk_all("in_rst", zero_v, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_all("post_rst1", zero_v, 1'b0);
    apply(32'h80000537, 1'b0);
    chk_all("post_rst2", zero_v, 1'b0);
    apply(32'h80000537, 1'b1);
    chk_all("post_rst_load", vecs[7], 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
